// File: rtl/prefetch_queue.sv
// prefetch_queue: byte ring buffer feeding pre_decode, with a single-outstanding word fetcher.
// Optional stall counter output is enabled by defining PREFETCH_STALL_CNT_EN.
module prefetch_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  input  logic              consume,
  input  logic [3:0]        consume_len,
  output logic [3:0]        q_len,
  output logic [7:0]        q0,
  output logic [7:0]        q1,
  output logic [7:0]        q2,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic [15:0]       fetch_data
`ifdef PREFETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [ADDR_W-1:0] nfp;

  logic [3:0] free;
  logic [3:0] need;
  logic [3:0] used;
  logic [3:0] added;
  logic       wr_en;

  always_comb begin
    free  = 4'(DEPTH) - q_len;
    need  = nfp[0] ? 4'd1 : 4'd2;
    used  = '0;
    if (consume) used = (consume_len > q_len) ? q_len : consume_len;
    wr_en = (state == REQ) && fetch_ack && !flush;
    added = '0;
    if (wr_en) added = fetch_addr[0] ? 4'd1 : 4'd2;
  end

  // Head bytes are gated by the registered count so stale slots read as zero.
  always_comb begin
    q0 = (q_len > 4'd0) ? mem[head]           : 8'h00;
    q1 = (q_len > 4'd1) ? mem[head + PW'(1)]  : 8'h00;
    q2 = (q_len > 4'd2) ? mem[head + PW'(2)]  : 8'h00;
  end

  // NOTE: the byte storage has no reset; q_len gates every read, so stale bytes are never visible.
  always_ff @(posedge clk) begin
    if (ce && wr_en) begin
      if (fetch_addr[0]) begin
        mem[tail] <= fetch_data[15:8];
      end else begin
        mem[tail]          <= fetch_data[7:0];
        mem[tail + PW'(1)] <= fetch_data[15:8];
      end
    end
  end

  // NOTE: non-blocking assignments keep every branch working from the pre-edge q_len and state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      q_len      <= '0;
      nfp        <= '0;
      fetch_req  <= 1'b0;
      fetch_addr <= '0;
    end else if (ce) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        q_len <= '0;
        nfp   <= flush_addr;
        // A bus cycle in flight cannot be aborted; wait out its ack in DISCARD.
        if (state != IDLE && !fetch_ack) begin
          state <= DISCARD;
        end else begin
          state     <= IDLE;
          fetch_req <= 1'b0;
        end
      end else begin
        head  <= head + PW'(used);
        q_len <= q_len - used + added;
        if (wr_en) begin
          tail <= tail + PW'(added);
          nfp  <= nfp + ADDR_W'(added);
        end
        case (state)
          IDLE: begin
            if (free >= need) begin
              state      <= REQ;
              fetch_req  <= 1'b1;
              fetch_addr <= nfp;
            end
          end
          REQ, DISCARD: begin
            if (fetch_ack) begin
              state     <= IDLE;
              fetch_req <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PREFETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (ce) begin
      if (flush) stall_cnt <= '0;
      else if (q_len == 4'd0 && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  // Over-consumption is clamped in hardware; flag it so the sequencer bug is visible.
  always_ff @(posedge clk) begin
    if (reset_n && ce && consume && !flush)
      assert (consume_len <= q_len)
      else $warning("prefetch_queue: consume_len %0d exceeds q_len %0d, clamped", consume_len, q_len);
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: directed scenarios plus randomized traffic
// compared against a byte-queue reference model.
module tb_prefetch_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ce = 1'b1;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] flush_addr = '0;
  logic              consume = 1'b0;
  logic [3:0]        consume_len = 4'd1;
  logic [3:0]        q_len;
  logic [7:0]        q0, q1, q2;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack = 1'b0;
  logic [15:0]       fetch_data = '0;
`ifdef PREFETCH_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .flush      (flush),
    .flush_addr (flush_addr),
    .consume    (consume),
    .consume_len(consume_len),
    .q_len      (q_len),
    .q0         (q0),
    .q1         (q1),
    .q2         (q2),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data)
`ifdef PREFETCH_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of bytes plus the outstanding bus request.
  typedef enum {M_IDLE, M_REQ, M_DISC} mstate_t;
  logic [7:0]        mq[$];
  mstate_t           m_st;
  logic [ADDR_W-1:0] m_nfp;
  logic [ADDR_W-1:0] m_addr;
  logic              m_req;
  int                m_stall;

  task automatic model_reset();
    mq.delete();
    m_st    = M_IDLE;
    m_nfp   = '0;
    m_addr  = '0;
    m_req   = 1'b0;
    m_stall = 0;
  endtask

  task automatic model_update(input logic f, input logic [ADDR_W-1:0] fa, input logic c,
                              input int cl, input logic a, input logic [15:0] d);
    int ql;
    int n;
    ql = mq.size();
    if (f) begin
      mq.delete();
      m_nfp   = fa;
      m_stall = 0;
      if (m_st != M_IDLE && !a) m_st = M_DISC;
      else begin
        m_st  = M_IDLE;
        m_req = 1'b0;
      end
    end else begin
      n = c ? ((cl > ql) ? ql : cl) : 0;
      if (ql == 0 && m_stall < 65535) m_stall++;
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      case (m_st)
        M_IDLE: if (DEPTH - ql >= (m_nfp[0] ? 1 : 2)) begin
          m_st   = M_REQ;
          m_req  = 1'b1;
          m_addr = m_nfp;
        end
        M_REQ: if (a) begin
          if (m_addr[0]) begin
            mq.push_back(d[15:8]);
            m_nfp = m_nfp + 20'd1;
          end else begin
            mq.push_back(d[7:0]);
            mq.push_back(d[15:8]);
            m_nfp = m_nfp + 20'd2;
          end
          m_st  = M_IDLE;
          m_req = 1'b0;
        end
        default: if (a) begin
          m_st  = M_IDLE;
          m_req = 1'b0;
        end
      endcase
    end
  endtask

  function automatic logic [7:0] exp_q(int i);
    return (i < mq.size()) ? mq[i] : 8'h00;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, then sample 1 ns later.
  task automatic step(input logic f, input logic [ADDR_W-1:0] fa, input logic c, input logic [3:0] cl,
                      input logic a, input logic [15:0] d, input logic e = 1'b1);
    ce = e; flush = f; flush_addr = fa; consume = c; consume_len = cl;
    fetch_ack = a; fetch_data = d;
    @(posedge clk);
    if (e) model_update(f, fa, c, int'(cl), a, d);
    #1;
    ce = 1'b1; flush = 1'b0; consume = 1'b0; fetch_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 4'd1, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q_len !== 4'd0) begin errors++; $display("FAIL reset_q_len: got %0d expected 0", q_len); end
    checks++; if ({q0, q1, q2} !== 24'h0) begin errors++; $display("FAIL reset_q: got %h expected 000000", {q0, q1, q2}); end
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_fetch_req: got %b expected 0", fetch_req); end
    checks++; if (fetch_addr !== 20'h0) begin errors++; $display("FAIL reset_fetch_addr: got %h expected 00000", fetch_addr); end
`ifdef PREFETCH_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt: got %h expected 0000", stall_cnt); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_even_fetch();
    step(1'b1, 20'h00100, 1'b0, 4'd1, 1'b0, 16'h0);
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL even_flush_gap: got %b expected 0", fetch_req); end
    idle(1);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 20'h00100)
      begin errors++; $display("FAIL even_req: got req=%b addr=%h expected req=1 addr=00100", fetch_req, fetch_addr); end
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'hBBAA);
    checks++; if (q_len !== 4'd2) begin errors++; $display("FAIL even_q_len: got %0d expected 2", q_len); end
    checks++; if ({q0, q1, q2} !== 24'hAABB00) begin errors++; $display("FAIL even_bytes: got %h expected AABB00", {q0, q1, q2}); end
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL even_req_drop: got %b expected 0", fetch_req); end
  endtask

  task automatic test_odd_fetch();
    step(1'b1, 20'h00201, 1'b0, 4'd1, 1'b0, 16'h0);
    checks++; if (q_len !== 4'd0) begin errors++; $display("FAIL odd_flush_clear: got %0d expected 0", q_len); end
    idle(1);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 20'h00201)
      begin errors++; $display("FAIL odd_req: got req=%b addr=%h expected req=1 addr=00201", fetch_req, fetch_addr); end
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'h3412);
    checks++; if (q_len !== 4'd1) begin errors++; $display("FAIL odd_q_len: got %0d expected 1", q_len); end
    checks++; if ({q0, q1} !== 16'h3400) begin errors++; $display("FAIL odd_bytes: got %h expected 3400", {q0, q1}); end
    idle(1);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 20'h00202)
      begin errors++; $display("FAIL odd_next_req: got req=%b addr=%h expected req=1 addr=00202", fetch_req, fetch_addr); end
  endtask

  task automatic test_fill_stall();
    logic seen_req;
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'h5655);
    idle(1);
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'h5857);
    idle(1);
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'h5A59);
    checks++; if (q_len !== 4'd7) begin errors++; $display("FAIL fill_q_len: got %0d expected 7", q_len); end
    seen_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      seen_req = seen_req | fetch_req;
    end
    checks++; if (seen_req !== 1'b0) begin errors++; $display("FAIL fill_no_req: got %b expected 0", seen_req); end
    step(1'b0, '0, 1'b1, 4'd3, 1'b0, 16'h0);
    checks++; if (q_len !== 4'd4 || q0 !== 8'h57)
      begin errors++; $display("FAIL fill_consume: got len=%0d q0=%h expected len=4 q0=57", q_len, q0); end
    idle(1);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 20'h00208)
      begin errors++; $display("FAIL fill_resume_req: got req=%b addr=%h expected req=1 addr=00208", fetch_req, fetch_addr); end
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'h5C5B);
    checks++; if (q_len !== 4'd6) begin errors++; $display("FAIL fill_refill: got %0d expected 6", q_len); end
  endtask

  task automatic test_consume_ack();
    step(1'b0, '0, 1'b1, 4'd2, 1'b0, 16'h0);
    checks++; if (q_len !== 4'd4 || fetch_req !== 1'b1)
      begin errors++; $display("FAIL ca_setup: got len=%0d req=%b expected len=4 req=1", q_len, fetch_req); end
    step(1'b0, '0, 1'b1, 4'd2, 1'b1, 16'h5E5D);
    checks++; if (q_len !== 4'd4) begin errors++; $display("FAIL ca_q_len: got %0d expected 4", q_len); end
    checks++; if ({q0, q1, q2} !== 24'h5B5C5D) begin errors++; $display("FAIL ca_bytes: got %h expected 5B5C5D", {q0, q1, q2}); end
  endtask

  task automatic test_flush_pending();
    idle(1);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 20'h0020C)
      begin errors++; $display("FAIL fp_req: got req=%b addr=%h expected req=1 addr=0020C", fetch_req, fetch_addr); end
    step(1'b1, 20'h00300, 1'b0, 4'd1, 1'b0, 16'h0);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 20'h0020C || q_len !== 4'd0)
      begin errors++; $display("FAIL fp_hold: got req=%b addr=%h len=%0d expected req=1 addr=0020C len=0", fetch_req, fetch_addr, q_len); end
    idle(2);
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'hDEAD);
    checks++; if (fetch_req !== 1'b0 || q_len !== 4'd0)
      begin errors++; $display("FAIL fp_drop: got req=%b len=%0d expected req=0 len=0", fetch_req, q_len); end
    idle(1);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 20'h00300)
      begin errors++; $display("FAIL fp_new_req: got req=%b addr=%h expected req=1 addr=00300", fetch_req, fetch_addr); end
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'h2211, 1'b0);
    checks++; if (fetch_req !== 1'b1 || q_len !== 4'd0)
      begin errors++; $display("FAIL ce_hold: got req=%b len=%0d expected req=1 len=0", fetch_req, q_len); end
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'h2211);
    checks++; if (q_len !== 4'd2 || {q0, q1} !== 16'h1122)
      begin errors++; $display("FAIL ce_ack: got len=%0d q=%h expected len=2 q=1122", q_len, {q0, q1}); end
  endtask

  task automatic test_async_reset();
    idle(1);
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL ar_setup: got %b expected 1", fetch_req); end
    reset_n = 1'b0;
    #2;
    checks++; if (fetch_req !== 1'b0 || q_len !== 4'd0 || fetch_addr !== 20'h0)
      begin errors++; $display("FAIL ar_immediate: got req=%b len=%0d addr=%h expected 0/0/00000", fetch_req, q_len, fetch_addr); end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_ring_wrap_clamp();
    int nxt;
    int cyc;
    logic do_c;
    logic [ADDR_W-1:0] off;
    do_reset();
    step(1'b1, 20'h00400, 1'b0, 4'd1, 1'b0, 16'h0);
    nxt = 0;
    cyc = 0;
    while (nxt < 20 && cyc < 300) begin
      do_c = (q_len != 4'd0);
      if (do_c) begin
        checks++; if (q0 !== 8'(nxt)) begin errors++; $display("FAIL wrap_q0: got %h expected %h", q0, 8'(nxt)); end
        nxt++;
      end
      off = fetch_addr - 20'h00400;
      step(1'b0, '0, do_c, 4'd1, fetch_req, {off[7:0] + 8'd1, off[7:0]});
      checks++; if (q_len !== 4'(mq.size())) begin errors++; $display("FAIL wrap_q_len: got %0d expected %0d", q_len, mq.size()); end
      cyc++;
    end
    checks++; if (nxt < 20) begin errors++; $display("FAIL wrap_timeout: got %0d bytes expected 20", nxt); end

    do_reset();
    step(1'b1, 20'h00501, 1'b0, 4'd1, 1'b0, 16'h0);
    idle(1);
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'hA1FF);
    idle(1);
    step(1'b0, '0, 1'b0, 4'd1, 1'b1, 16'hA3A2);
    checks++; if (q_len !== 4'd3 || {q0, q1, q2} !== 24'hA1A2A3)
      begin errors++; $display("FAIL clamp_setup: got len=%0d q=%h expected len=3 q=A1A2A3", q_len, {q0, q1, q2}); end
    step(1'b0, '0, 1'b1, 4'd5, 1'b0, 16'h0);
    checks++; if (q_len !== 4'd0 || q0 !== 8'h00)
      begin errors++; $display("FAIL clamp: got len=%0d q0=%h expected len=0 q0=00", q_len, q0); end
  endtask

  task automatic test_random();
    logic f, c, a, e;
    logic [ADDR_W-1:0] fa;
    logic [15:0] d;
    int cl;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      f  = ($urandom_range(0, 19) == 0);
      fa = 20'($urandom);
      e  = ($urandom_range(0, 9) != 0);
      c  = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      cl = c ? int'($urandom_range(1, mq.size())) : 1;
      a  = fetch_req && ($urandom_range(0, 1) == 1);
      d  = 16'($urandom);
      step(f, fa, c, 4'(cl), a, d, e);
      checks++; if (q_len !== 4'(mq.size()))
        begin errors++; if (errors <= 20) $display("FAIL rand_q_len: got %0d expected %0d", q_len, mq.size()); end
      checks++; if ({q0, q1, q2} !== {exp_q(0), exp_q(1), exp_q(2)})
        begin errors++; if (errors <= 20) $display("FAIL rand_q: got %h expected %h", {q0, q1, q2}, {exp_q(0), exp_q(1), exp_q(2)}); end
      checks++; if (fetch_req !== m_req)
        begin errors++; if (errors <= 20) $display("FAIL rand_req: got %b expected %b", fetch_req, m_req); end
      checks++; if (fetch_addr !== m_addr)
        begin errors++; if (errors <= 20) $display("FAIL rand_addr: got %h expected %h", fetch_addr, m_addr); end
`ifdef PREFETCH_STALL_CNT_EN
      checks++; if (stall_cnt !== 16'(m_stall))
        begin errors++; if (errors <= 20) $display("FAIL rand_stall: got %0d expected %0d", stall_cnt, m_stall); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_even_fetch();
    test_odd_fetch();
    test_fill_stall();
    test_consume_ack();
    test_flush_pending();
    test_async_reset();
    test_ring_wrap_clamp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
